// File: rtl/ip_eth_header_writer_if.sv
// Frame-header request bundle plus the RAM port-B write bus.
// master: the requester that starts a header and observes the RAM writes.
// slave: the header writer itself.
interface ip_eth_header_writer_if;
  logic        iStart;
  logic [47:0] iDstMac;
  logic [31:0] iDstIp;
  logic [15:0] iUdpLen;
  logic [15:0] iIdent;
  logic        wren_b;
  logic [7:0]  data_b;
  logic [9:0]  address_b;
  logic        oBusy;
  logic        oDone;

  modport master (
    output iStart, iDstMac, iDstIp, iUdpLen, iIdent,
    input  wren_b, data_b, address_b, oBusy, oDone
  );

  modport slave (
    input  iStart, iDstMac, iDstIp, iUdpLen, iIdent,
    output wren_b, data_b, address_b, oBusy, oDone
  );
endinterface

// File: rtl/ip_eth_header_writer.sv
// Writes the 34-byte Ethernet II + IPv4 header (checksum included) into the TX frame RAM.
// Latency: 10 checksum cycles, 1 fold cycle, 34 write/advance pairs, 1 done cycle (80 cycles).
// No backpressure: the RAM accepts a write every WRITE cycle; iStart is ignored while busy.
module ip_eth_header_writer #(
  parameter logic [47:0] SRC_MAC  = 48'h00_60_6E_90_00_AE,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_000A,
  parameter logic [7:0]  IP_TTL   = 8'h80,
  parameter logic [9:0]  HDR_BASE = 10'd0
) (
  input  logic                   iDm9000aClk,
  input  logic                   iRst_n,
  ip_eth_header_writer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CSUM  = 3'd1,
    S_FOLD  = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [5:0] LAST_BYTE = 6'd33;
  localparam logic [3:0] LAST_WORD = 4'd9;

  state_t      state_q, state_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [15:0] ident_q, ident_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  widx_q, widx_d;
  logic [15:0] csum_q, csum_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [9:0]  addr_q, addr_d;

  logic [15:0] hdr_word;
  logic [16:0] fold_s1;
  logic [15:0] fold_s2;
  logic [5:0]  byte_idx;
  logic [7:0]  hdr_byte;

  // Header word fed to the one's-complement accumulator on each CSUM cycle.
  always_comb begin
    hdr_word = 16'h0000;
    case (widx_q)
      4'd0:    hdr_word = 16'h4500;
      4'd1:    hdr_word = tot_len_q;
      4'd2:    hdr_word = ident_q;
      4'd3:    hdr_word = 16'h4000;
      4'd4:    hdr_word = {IP_TTL, 8'h11};
      4'd5:    hdr_word = 16'h0000;
      4'd6:    hdr_word = SRC_IP[31:16];
      4'd7:    hdr_word = SRC_IP[15:0];
      4'd8:    hdr_word = dst_ip_q[31:16];
      4'd9:    hdr_word = dst_ip_q[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

  // Two end-around-carry folds; the second can no longer overflow 16 bits.
  always_comb begin
    fold_s1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    fold_s2 = fold_s1[15:0] + {15'd0, fold_s1[16]};
  end

  // Byte that the next WRITE cycle will present; index 0 when leaving FOLD.
  always_comb begin
    byte_idx = (state_q == S_FOLD) ? 6'd0 : cnt_q + 6'd1;
    hdr_byte = 8'h00;
    case (byte_idx)
      6'd0:    hdr_byte = dst_mac_q[47:40];
      6'd1:    hdr_byte = dst_mac_q[39:32];
      6'd2:    hdr_byte = dst_mac_q[31:24];
      6'd3:    hdr_byte = dst_mac_q[23:16];
      6'd4:    hdr_byte = dst_mac_q[15:8];
      6'd5:    hdr_byte = dst_mac_q[7:0];
      6'd6:    hdr_byte = SRC_MAC[47:40];
      6'd7:    hdr_byte = SRC_MAC[39:32];
      6'd8:    hdr_byte = SRC_MAC[31:24];
      6'd9:    hdr_byte = SRC_MAC[23:16];
      6'd10:   hdr_byte = SRC_MAC[15:8];
      6'd11:   hdr_byte = SRC_MAC[7:0];
      6'd12:   hdr_byte = 8'h08;
      6'd13:   hdr_byte = 8'h00;
      6'd14:   hdr_byte = 8'h45;
      6'd15:   hdr_byte = 8'h00;
      6'd16:   hdr_byte = tot_len_q[15:8];
      6'd17:   hdr_byte = tot_len_q[7:0];
      6'd18:   hdr_byte = ident_q[15:8];
      6'd19:   hdr_byte = ident_q[7:0];
      6'd20:   hdr_byte = 8'h40;
      6'd21:   hdr_byte = 8'h00;
      6'd22:   hdr_byte = IP_TTL;
      6'd23:   hdr_byte = 8'h11;
      6'd24:   hdr_byte = csum_q[15:8];
      6'd25:   hdr_byte = csum_q[7:0];
      6'd26:   hdr_byte = SRC_IP[31:24];
      6'd27:   hdr_byte = SRC_IP[23:16];
      6'd28:   hdr_byte = SRC_IP[15:8];
      6'd29:   hdr_byte = SRC_IP[7:0];
      6'd30:   hdr_byte = dst_ip_q[31:24];
      6'd31:   hdr_byte = dst_ip_q[23:16];
      6'd32:   hdr_byte = dst_ip_q[15:8];
      6'd33:   hdr_byte = dst_ip_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Next-state logic: latch request, sum words, fold, then alternate WRITE/NEXT.
  always_comb begin
    state_d   = state_q;
    dst_mac_d = dst_mac_q;
    dst_ip_d  = dst_ip_q;
    tot_len_d = tot_len_q;
    ident_d   = ident_q;
    acc_d     = acc_q;
    widx_d    = widx_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    addr_d    = addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          dst_mac_d = bus.iDstMac;
          dst_ip_d  = bus.iDstIp;
          tot_len_d = bus.iUdpLen + 16'd20;
          ident_d   = bus.iIdent;
          acc_d     = 20'd0;
          widx_d    = 4'd0;
          state_d   = S_CSUM;
        end
      end
      S_CSUM: begin
        acc_d  = acc_q + {4'd0, hdr_word};
        widx_d = widx_q + 4'd1;
        if (widx_q == LAST_WORD) begin
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        csum_d  = ~fold_s2;
        cnt_d   = 6'd0;
        addr_d  = HDR_BASE;
        data_d  = hdr_byte;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cnt_q < LAST_BYTE) begin
          cnt_d   = cnt_q + 6'd1;
          addr_d  = addr_q + 10'd1;
          data_d  = hdr_byte;
          state_d = S_WRITE;
        end else begin
          addr_d  = 10'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any frame in progress.
  always_ff @(posedge iDm9000aClk) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      dst_mac_q <= 48'd0;
      dst_ip_q  <= 32'd0;
      tot_len_q <= 16'd0;
      ident_q   <= 16'd0;
      acc_q     <= 20'd0;
      widx_q    <= 4'd0;
      csum_q    <= 16'd0;
      cnt_q     <= 6'd0;
      data_q    <= 8'd0;
      addr_q    <= 10'd0;
    end else begin
      state_q   <= state_d;
      dst_mac_q <= dst_mac_d;
      dst_ip_q  <= dst_ip_d;
      tot_len_q <= tot_len_d;
      ident_q   <= ident_d;
      acc_q     <= acc_d;
      widx_q    <= widx_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
    end
  end

  assign bus.wren_b    = (state_q == S_WRITE);
  assign bus.oDone     = (state_q == S_DONE);
  assign bus.oBusy     = (state_q != S_IDLE);
  assign bus.data_b    = data_q;
  assign bus.address_b = addr_q;

endmodule

// File: tb/tb_ip_eth_header_writer.sv
// Bench for ip_eth_header_writer: a timeline/byte-map model predicts every output each cycle,
// and literal header bytes pin the model for the hand-worked cases.
`timescale 1ns/1ps
module tb_ip_eth_header_writer;
  localparam logic [47:0] SRC_MAC  = 48'h00_60_6E_90_00_AE;
  localparam logic [31:0] SRC_IP   = 32'hC0A8_000A;
  localparam logic [7:0]  IP_TTL   = 8'h80;
  localparam int          HDR_BASE = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ip_eth_header_writer_if bus();

  ip_eth_header_writer dut (
    .iDm9000aClk (clk),
    .iRst_n      (rst_n),
    .bus         (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  bit         active = 1'b0;
  int         e_edge = 0;
  logic [7:0] exp_b [34];
  logic [7:0] cap   [34];
  int         wr_cnt = 0;
  int         done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference header: straight byte map plus a textbook one's-complement sum.
  task automatic build(input logic [47:0] mac, input logic [31:0] ip,
                       input logic [15:0] len, input logic [15:0] id);
    logic [15:0] tl;
    logic [15:0] w [10];
    int unsigned s;
    logic [15:0] cs;
    tl = 16'(len + 16'd20);
    w[0] = 16'h4500; w[1] = tl; w[2] = id; w[3] = 16'h4000;
    w[4] = {IP_TTL, 8'h11}; w[5] = 16'h0000;
    w[6] = SRC_IP[31:16]; w[7] = SRC_IP[15:0]; w[8] = ip[31:16]; w[9] = ip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    for (int i = 0; i < 6; i++) begin
      exp_b[i]     = 8'(mac >> (8 * (5 - i)));
      exp_b[6 + i] = 8'(SRC_MAC >> (8 * (5 - i)));
    end
    exp_b[12] = 8'h08; exp_b[13] = 8'h00; exp_b[14] = 8'h45; exp_b[15] = 8'h00;
    exp_b[16] = tl[15:8]; exp_b[17] = tl[7:0];
    exp_b[18] = id[15:8]; exp_b[19] = id[7:0];
    exp_b[20] = 8'h40; exp_b[21] = 8'h00; exp_b[22] = IP_TTL; exp_b[23] = 8'h11;
    exp_b[24] = cs[15:8]; exp_b[25] = cs[7:0];
    for (int i = 0; i < 4; i++) begin
      exp_b[26 + i] = 8'(SRC_IP >> (8 * (3 - i)));
      exp_b[30 + i] = 8'(ip >> (8 * (3 - i)));
    end
  endtask

  // Per-cycle compare against the model's timeline, then decide what the next edge does.
  always @(negedge clk) begin
    int off;
    int k;
    bit ew;
    if (chk_en) begin
      off = cyc + 1 - e_edge;
      if (active && off > 80) active = 1'b0;
      ew = active && off >= 12 && off <= 78 && (off % 2 == 0);
      k = (off - 12) / 2;
      chk("wren_b", bus.wren_b, ew);
      chk("oBusy", bus.oBusy, active);
      chk("oDone", bus.oDone, active && off == 80);
      if (ew) begin
        chk("address_b", bus.address_b, 10'(HDR_BASE + k));
        chk("data_b", bus.data_b, exp_b[k]);
      end
      if (!active) chk("idle_address_b", bus.address_b, 10'd0);
      if (bus.wren_b === 1'b1 && int'(bus.address_b) < 34) begin
        cap[bus.address_b] = bus.data_b;
        wr_cnt++;
      end
      if (bus.oDone === 1'b1) done_cnt++;
      if (!rst_n) begin
        active = 1'b0;
      end else if (bus.iStart && !active) begin
        active = 1'b1;
        e_edge = cyc + 1;
        build(bus.iDstMac, bus.iDstIp, bus.iUdpLen, bus.iIdent);
      end
    end
  end

  // Caller sits just after an edge; the following edge samples iStart.
  task automatic start_frame(input logic [47:0] mac, input logic [31:0] ip,
                             input logic [15:0] len, input logic [15:0] id);
    bus.iDstMac = mac; bus.iDstIp = ip; bus.iUdpLen = len; bus.iIdent = id;
    bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
  endtask

  // Advance n edges; stray iStart pulses are sampled at edges E+sa and E+sb.
  task automatic run_edges(input int n, input int sa, input int sb);
    for (int k = 1; k <= n; k++) begin
      bus.iStart = (k == sa || k == sb);
      @(posedge clk); #1;
    end
    bus.iStart = 1'b0;
  endtask

  task automatic frame(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] len,
                       input logic [15:0] id, input int sa, input int sb, input bit b2b);
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(mac, ip, len, id);
    run_edges(80, sa, sb);
    if (b2b) begin
      start_frame(mac, ip, len, id);
      run_edges(80, 0, 0);
    end
    run_edges(2, 0, 0);
    chk("done_count", done_cnt - d0, b2b ? 2 : 1);
    chk("write_count", wr_cnt - w0, b2b ? 68 : 34);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    bus.iStart = 1'b0; bus.iDstMac = '0; bus.iDstIp = '0; bus.iUdpLen = '0; bus.iIdent = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_edges(20, 0, 0);

    // Default stimulus: checksum 0x7963 worked by hand.
    frame(48'hFFFF_FFFF_FFFF, 32'hC0A8_0001, 16'd26, 16'h0000, 0, 0, 1'b0);
    chk("byte0", cap[0], 8'hFF);
    chk("byte5", cap[5], 8'hFF);
    chk("byte16", cap[16], 8'h00);
    chk("byte17", cap[17], 8'h2E);
    chk("byte24", cap[24], 8'h79);
    chk("byte25", cap[25], 8'h63);

    // Identification 0x1234: checksum drops by 0x1234 to 0x672F.
    frame(48'hFFFF_FFFF_FFFF, 32'hC0A8_0001, 16'd26, 16'h1234, 0, 0, 1'b0);
    chk("ident_byte18", cap[18], 8'h12);
    chk("ident_byte19", cap[19], 8'h34);
    chk("ident_byte24", cap[24], 8'h67);
    chk("ident_byte25", cap[25], 8'h2F);

    // Stray starts while busy are ignored; a start at E+81 launches a second frame.
    frame(48'hFFFF_FFFF_FFFF, 32'hC0A8_0001, 16'd26, 16'h0000, 5, 40, 1'b1);

    // Reset mid-frame: no oDone, then a clean frame.
    d0 = done_cnt;
    start_frame(48'h0201_0203_0405, 32'h0A00_0001, 16'd100, 16'h00AA);
    run_edges(29, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_edges(90, 0, 0);
    chk("reset_no_done", done_cnt - d0, 0);
    frame(48'hFFFF_FFFF_FFFF, 32'hC0A8_0001, 16'd26, 16'h0000, 0, 0, 1'b0);
    chk("after_reset_byte24", cap[24], 8'h79);

    // TotLen wraps: 0xFFF0 + 20 = 0x0004, checksum 0x798D.
    frame(48'hFFFF_FFFF_FFFF, 32'hC0A8_0001, 16'hFFF0, 16'h0000, 0, 0, 1'b0);
    chk("wrap_byte16", cap[16], 8'h00);
    chk("wrap_byte17", cap[17], 8'h04);
    chk("wrap_byte24", cap[24], 8'h79);
    chk("wrap_byte25", cap[25], 8'h8D);

    // Randomized frames with stray starts and optional back-to-back launches.
    for (int r = 0; r < 8; r++) begin
      frame({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, $urandom, 16'($urandom), 16'($urandom),
            $urandom_range(1, 79), $urandom_range(1, 79), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
